// File: rtl/fft_pkg.sv
// Shared FFT datapath types: complex single-precision sample and the
// sign-bit conjugation helper used by the commutator, butterfly and twiddle stages.
package fft_pkg;

    localparam int unsigned DW       = 32;
    localparam int unsigned SIGN_BIT = 31;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    // Conjugate by flipping only the imaginary sign bit; NaN/Inf/zero stay bitwise.
    function automatic cplx_t conj(input cplx_t x);
        cplx_t y;
        y               = x;
        y.im[SIGN_BIT]  = ~x.im[SIGN_BIT];
        return y;
    endfunction

    typedef enum logic [1:0] {
        PH_BANK0 = 2'd0,
        PH_BANK1 = 2'd1,
        PH_OUT   = 2'd2
    } phase_e;

endpackage

// File: rtl/tri_commutator_if.sv
// Sample stream in, butterfly triplet out, for the radix-3 input commutator.
interface tri_commutator_if;

    logic        in_valid;
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic        inv;

    logic        out_valid;
    logic        out_first;
    logic [31:0] out0_re;
    logic [31:0] out0_im;
    logic [31:0] out1_re;
    logic [31:0] out1_im;
    logic [31:0] out2_re;
    logic [31:0] out2_im;

    modport master (
        output in_valid, in_re, in_im, inv,
        input  out_valid, out_first,
               out0_re, out0_im, out1_re, out1_im, out2_re, out2_im
    );

    modport slave (
        input  in_valid, in_re, in_im, inv,
        output out_valid, out_first,
               out0_re, out0_im, out1_re, out1_im, out2_re, out2_im
    );

endinterface

// File: rtl/tri_commutator_bank.sv
// DEPTH-entry complex sample store: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module tri_bank
    import fft_pkg::cplx_t;
#(
    parameter int unsigned DEPTH = 3,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  cplx_t         wdata,
    input  logic [AW-1:0] raddr,
    output cplx_t         rdata_c
);

    cplx_t mem_q [DEPTH];
    cplx_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/tri_commutator.sv
// Radix-3 SDF input commutator: buffers phases 0 and 1 of each group and
// emits (x[k], x[k+D], x[k+2D]) triplets during phase 2, optionally conjugated.
module tri_commutator
    import fft_pkg::cplx_t;
    import fft_pkg::conj;
    import fft_pkg::phase_e;
    import fft_pkg::PH_BANK0;
    import fft_pkg::PH_BANK1;
    import fft_pkg::PH_OUT;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    tri_commutator_if.slave     bus
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

    if (DW != 32 || !(DEPTH == 1 || DEPTH == 3 || DEPTH == 9)) begin : g_bad_param
        $error("tri_commutator: DW must be 32 and DEPTH one of 1, 3, 9");
    end

    phase_e        phase_q, phase_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          inv_q, inv_d;
    logic          out_valid_q, out_valid_d;
    logic          out_first_q, out_first_d;
    cplx_t         out0_q, out0_d;
    cplx_t         out1_q, out1_d;
    cplx_t         out2_q, out2_d;

    cplx_t         in_c;
    cplx_t         bank0_rd_c;
    cplx_t         bank1_rd_c;
    logic          bank0_we_c;
    logic          bank1_we_c;

    assign in_c       = '{re: bus.in_re, im: bus.in_im};
    assign bank0_we_c = bus.in_valid && (phase_q == PH_BANK0);
    assign bank1_we_c = bus.in_valid && (phase_q == PH_BANK1);

    tri_bank #(.DEPTH(DEPTH)) bank0 (
        .clk     (clk),
        .we      (bank0_we_c),
        .waddr   (idx_q),
        .wdata   (in_c),
        .raddr   (idx_q),
        .rdata_c (bank0_rd_c)
    );

    tri_bank #(.DEPTH(DEPTH)) bank1 (
        .clk     (clk),
        .we      (bank1_we_c),
        .waddr   (idx_q),
        .wdata   (in_c),
        .raddr   (idx_q),
        .rdata_c (bank1_rd_c)
    );

    // Counter advance, group-start inv capture and triplet load.
    always_comb begin
        phase_d     = phase_q;
        idx_d       = idx_q;
        inv_d       = inv_q;
        out_valid_d = 1'b0;
        out_first_d = out_first_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        out2_d      = out2_q;

        if (bus.in_valid) begin
            if (phase_q == PH_BANK0 && idx_q == '0) begin
                inv_d = bus.inv;
            end

            if (phase_q == PH_OUT) begin
                out_valid_d = 1'b1;
                out_first_d = (idx_q == '0);
                out0_d      = inv_q ? conj(bank0_rd_c) : bank0_rd_c;
                out1_d      = inv_q ? conj(bank1_rd_c) : bank1_rd_c;
                out2_d      = inv_q ? conj(in_c)       : in_c;
            end

            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                case (phase_q)
                    PH_BANK0: phase_d = PH_BANK1;
                    PH_BANK1: phase_d = PH_OUT;
                    default:  phase_d = PH_BANK0;
                endcase
            end else begin
                idx_d = idx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_BANK0;
            idx_q       <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
        end else begin
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            inv_q       <= inv_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out0_re   = out0_q.re;
    assign bus.out0_im   = out0_q.im;
    assign bus.out1_re   = out1_q.re;
    assign bus.out1_im   = out1_q.im;
    assign bus.out2_re   = out2_q.re;
    assign bus.out2_im   = out2_q.im;

endmodule

// File: tb/tb_tri_commutator.sv
// Directed vector bench for tri_commutator at DEPTH=3 and DEPTH=1.
module tb_tri_commutator;

    logic clk;
    logic rst;

    tri_commutator_if if3 ();
    tri_commutator_if if1 ();

    tri_commutator #(.DEPTH(3), .DW(32)) u_d3 (.clk(clk), .rst(rst), .bus(if3));
    tri_commutator #(.DEPTH(1), .DW(32)) u_d1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        int          n;
        bit          inv;
        logic [31:0] im;
        bit          ev;
        bit          ef;
        int          e0;
        int          e1;
        int          e2;
        logic [31:0] eim;
    } vec_t;

    vec_t tab[$];
    int   n_pass;
    int   n_total;

    localparam logic [31:0] IM_P1 = 32'h3F80_0000;
    localparam logic [31:0] IM_N1 = 32'hBF80_0000;

    // float(n) for the test samples; 0 selects a garbage word for gap cycles
    function automatic logic [31:0] fval(input int n);
        case (n)
            1:       return 32'h3F80_0000;
            2:       return 32'h4000_0000;
            3:       return 32'h4040_0000;
            4:       return 32'h4080_0000;
            5:       return 32'h40A0_0000;
            6:       return 32'h40C0_0000;
            7:       return 32'h40E0_0000;
            8:       return 32'h4100_0000;
            9:       return 32'h4110_0000;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input bit v, input int n, input bit inv, input logic [31:0] im,
                       input bit ev, input bit ef, input int e0, input int e1,
                       input int e2, input logic [31:0] eim);
        vec_t t;
        t.v = v; t.n = n; t.inv = inv; t.im = im;
        t.ev = ev; t.ef = ef; t.e0 = e0; t.e1 = e1; t.e2 = e2; t.eim = eim;
        tab.push_back(t);
    endtask

    // One DEPTH=3 group of samples 1..9, optional gap cycles carrying inv=1 and garbage
    task automatic add_grp(input bit inv1, input bit inv4, input logic [31:0] im,
                           input logic [31:0] eim, input bit gaps, input int g);
        for (int n = 1; n <= 9; n++) begin
            int ng;
            ng = (gaps && ((g * 9 + n) % 2 == 0)) ? ((n % 3 == 0) ? 2 : 1) : 0;
            for (int k = 0; k < ng; k++) add(1'b0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, 0, '0);
            add(1'b1, n, (n == 1) ? inv1 : ((n == 4) ? inv4 : 1'b0), im,
                n >= 7, n == 7, n - 6, n - 3, n, eim);
        end
    endtask

    task automatic drive(input vec_t t, input bit d1);
        if (d1) begin
            if1.in_valid = t.v; if1.in_re = fval(t.n); if1.in_im = t.im; if1.inv = t.inv;
            if3.in_valid = 1'b0;
        end else begin
            if3.in_valid = t.v; if3.in_re = fval(t.n); if3.in_im = t.im; if3.inv = t.inv;
            if1.in_valid = 1'b0;
        end
    endtask

    task automatic apply(input vec_t t, input bit d1, input string tag);
        logic        ov, of;
        logic [31:0] r0, r1, r2, i0, i1, i2;
        drive(t, d1);
        @(posedge clk);
        #1;
        if (d1) begin
            ov = if1.out_valid; of = if1.out_first;
            r0 = if1.out0_re; r1 = if1.out1_re; r2 = if1.out2_re;
            i0 = if1.out0_im; i1 = if1.out1_im; i2 = if1.out2_im;
        end else begin
            ov = if3.out_valid; of = if3.out_first;
            r0 = if3.out0_re; r1 = if3.out1_re; r2 = if3.out2_re;
            i0 = if3.out0_im; i1 = if3.out1_im; i2 = if3.out2_im;
        end
        chk({tag, " out_valid"}, 32'(ov), 32'(t.ev));
        if (t.ev) begin
            chk({tag, " out_first"}, 32'(of), 32'(t.ef));
            chk({tag, " out0_re"}, r0, fval(t.e0));
            chk({tag, " out1_re"}, r1, fval(t.e1));
            chk({tag, " out2_re"}, r2, fval(t.e2));
            chk({tag, " out0_im"}, i0, t.eim);
            chk({tag, " out1_im"}, i1, t.eim);
            chk({tag, " out2_im"}, i2, t.eim);
        end
    endtask

    task automatic chk_reset_state(input bit d1, input string tag);
        if (d1) begin
            chk({tag, " out_valid"}, 32'(if1.out_valid), 32'd0);
            chk({tag, " out_first"}, 32'(if1.out_first), 32'd0);
            chk({tag, " out0_re"}, if1.out0_re, '0);
            chk({tag, " out1_im"}, if1.out1_im, '0);
            chk({tag, " out2_re"}, if1.out2_re, '0);
        end else begin
            chk({tag, " out_valid"}, 32'(if3.out_valid), 32'd0);
            chk({tag, " out_first"}, 32'(if3.out_first), 32'd0);
            chk({tag, " out0_re"}, if3.out0_re, '0);
            chk({tag, " out0_im"}, if3.out0_im, '0);
            chk({tag, " out1_re"}, if3.out1_re, '0);
            chk({tag, " out1_im"}, if3.out1_im, '0);
            chk({tag, " out2_re"}, if3.out2_re, '0);
            chk({tag, " out2_im"}, if3.out2_im, '0);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        if3.in_valid = 1'b0; if3.in_re = '0; if3.in_im = '0; if3.inv = 1'b0;
        if1.in_valid = 1'b0; if1.in_re = '0; if1.in_im = '0; if1.inv = 1'b0;

        // plain, conjugated, mid-group inv toggle then next group, gapped groups
        add_grp(1'b0, 1'b0, '0,    '0,    1'b0, 0);
        add_grp(1'b1, 1'b0, IM_P1, IM_N1, 1'b0, 0);
        add_grp(1'b0, 1'b1, IM_P1, IM_P1, 1'b0, 0);
        add_grp(1'b1, 1'b0, IM_P1, IM_N1, 1'b0, 0);
        for (int g = 0; g < 4; g++) add_grp(1'b0, 1'b0, IM_P1, IM_P1, 1'b1, g);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_state(1'b0, "reset_d3");
        chk_reset_state(1'b1, "reset_d1");
        rst = 1'b0;

        foreach (tab[i]) apply(tab[i], 1'b0, $sformatf("vec%0d", i));

        // reset mid-group: partial group 1..5 is discarded
        tab.delete();
        for (int n = 1; n <= 5; n++) add(1'b1, n, 1'b0, '0, 1'b0, 1'b0, 0, 0, 0, '0);
        foreach (tab[i]) apply(tab[i], 1'b0, $sformatf("abort%0d", i));
        rst = 1'b1;
        if3.in_valid = 1'b1; if3.in_re = fval(6); if3.in_im = '0;
        @(posedge clk);
        #1;
        chk_reset_state(1'b0, "mid_reset");
        rst = 1'b0;
        tab.delete();
        add_grp(1'b0, 1'b0, '0, '0, 1'b0, 0);
        foreach (tab[i]) apply(tab[i], 1'b0, $sformatf("post_rst%0d", i));

        // DEPTH=1: every third sample forms a triplet, each flagged first
        tab.delete();
        for (int n = 1; n <= 6; n++)
            add(1'b1, n, 1'b0, '0, n % 3 == 0, 1'b1, n - 2, n - 1, n, '0);
        foreach (tab[i]) apply(tab[i], 1'b1, $sformatf("d1_%0d", i));

        if3.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_d3 out_valid", 32'(if3.out_valid), 32'd0);
        chk("idle_d1 out_valid", 32'(if1.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tri_commutator.md
# tri_commutator

Radix-3 single-delay-feedback input commutator for the Radix-3^2 FFT pipeline. It receives a serial stream of complex IEEE-754 single-precision samples and regroups them into butterfly triplets (x[k], x[k+D], x[k+2D]) for the downstream 3-point butterfly. An optional sign flip of the imaginary part conjugates the data on the read side, which lets the same pipeline compute an inverse FFT.

## Interface
Parameters:
- DEPTH, default 3: stage stride D, the number of samples per phase. Legal values: 1, 3 or 9.
- DW, default 32: width of one float word. Fixed at 32 (IEEE-754 single precision).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the input sample is valid this cycle. There is no backpressure.
- in_re  in  32  real part of the input sample (float).
- in_im  in  32  imaginary part of the input sample (float).
- inv  in  1  conjugate the output. Latched only at the start of a group.
- out_valid  out  1  the output triplet is valid.
- out_first  out  1  marks triplet index k=0 of a group.
- out0_re, out0_im  out  32 each  x[k], read from bank 0.
- out1_re, out1_im  out  32 each  x[k+D], read from bank 1.
- out2_re, out2_im  out  32 each  x[k+2D], the sample presented this cycle.

## Operation
- One group is 3·DEPTH accepted samples. Counters:
  - phase: 0..2.
  - idx: 0..DEPTH-1.
  - Both advance only on cycles with in_valid=1.
- Phase 0: the sample is written to bank0[idx]. No output.
- Phase 1: the sample is written to bank1[idx]. No output.
- Phase 2: the sample is not stored. The output registers load:
  - bank0[idx] into out0;
  - bank1[idx] into out1;
  - the live input into out2.
  - out_valid=1 on the next cycle.
  - out_first = (idx==0).
- Counter wrap:
  - idx wraps DEPTH-1 → 0 and increments phase.
  - phase wraps 2 → 0. The next group starts immediately, with no dead cycle.
- inv is sampled into inv_q when in_valid=1 and phase=0 and idx=0. inv_q holds for the whole group.
- Conjugation: when inv_q=1, bit 31 of all three out*_im words is inverted on load.
  - No other bits change.
  - ±0, NaN and Inf are treated bitwise only.
- Real parts always pass through unmodified.
- Gaps: when in_valid=0, the counters, banks and inv_q hold, and out_valid=0 on the next cycle. Gaps may occur anywhere, including mid-phase.
- Reset values:
  - phase=0, idx=0, inv_q=0.
  - out_valid=0, out_first=0.
  - All out* data registers = 0.
  - Bank contents are don't-care and are never read before being written.
- Reset asserted mid-group: the partial group is discarded. The first valid sample after reset is x[0] of a new group.
- DEPTH=1: banks are single registers. Every third valid sample produces a triplet, and out_first=1 on every triplet.

## Timing
- Latency: 1 cycle from the phase-2 input to the matching output.
- Throughput:
  - one sample per cycle in;
  - one triplet per cycle out during phase 2;
  - DEPTH triplets per 3·DEPTH valid inputs.
- out_valid is a single-cycle pulse per triplet, with no hold requirement on the consumer.
- Bank read and write share the same cycle only across different banks. A bank is never read and written in the same cycle.
- There are no combinational paths from inputs to outputs. All outputs are registered.

## Structure
- Shared package fft_pkg holds:
  - the DW=32 and SIGN_BIT=31 constants;
  - the cplx_t typedef {re[31:0], im[31:0]};
  - a conj function that flips im[31].
- The butterfly and twiddle stages reuse the same package.
- Sub-module tri_bank: a DEPTH×64-bit register array with one write port and one asynchronous read port. It is instantiated twice, as bank0 and bank1.
- The top level holds the phase/idx counters, inv_q, and the output register stage. Expected size is about 150–250 lines.

## Test plan
- DEPTH=3, inv=0. Input nine consecutive samples with re = float(n) for n=1..9 (0x3F800000, 0x40000000, …) and im=0x00000000.
  - Required: three triplets (1,4,7), (2,5,8), (3,6,9) on consecutive cycles.
  - out_first=1 on the first triplet only.
  - Each triplet appears one cycle after samples 7, 8 and 9 respectively.
- Same stream with inv=1 at sample 1 and im = 0x3F800000 on all samples.
  - Required: every out*_im = 0xBF800000. Real parts are unchanged.
- inv toggled to 1 at sample 4 mid-group.
  - Required: no conjugation in this group.
  - Conjugation applies from the next group, when inv=1 is present at its first sample.
- Random in_valid gaps (about 50%) over four groups.
  - Required: triplets and out_first are identical to the gapless run.
  - out_valid=0 on every cycle following a gap.
- rst pulsed after sample 5, then samples 1..9 again.
  - Required: no output from the aborted group.
  - Outputs are exactly (1,4,7), (2,5,8), (3,6,9).
- DEPTH=1: stream 1..6.
  - Required: triplets (1,2,3) and (4,5,6).
  - out_first=1 on both.
